// File: rtl/fi_pipe_injector.sv
// Fault-injection and observation shell around a WIDTH x DEPTH register pipeline.
// A timed controller corrupts one selected stage; a change monitor reports one stage.
module fi_pipe_injector #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 3,
    parameter  int unsigned CNT_W = 16,
    localparam int unsigned SW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       din,
    input  logic                   enable,
    output logic [DEPTH*WIDTH-1:0] stage_q,
    output logic [WIDTH-1:0]       dout,
    output logic [WIDTH-1:0]       dout_n,
    input  logic                   fi_arm,
    input  logic [SW-1:0]          fi_stage,
    input  logic [1:0]             fi_mode,
    input  logic [WIDTH-1:0]       fi_mask,
    input  logic [CNT_W-1:0]       fi_delay,
    input  logic [CNT_W-1:0]       fi_duration,
    input  logic                   fi_abort,
    output logic                   fi_busy,
    output logic                   fi_active,
    output logic                   fi_done,
    input  logic [SW-1:0]          obs_sel,
    output logic                   obs_valid,
    output logic [WIDTH-1:0]       obs_data,
    input  logic                   obs_ready,
    output logic                   obs_overflow,
    output logic [CNT_W-1:0]       obs_count
);
    localparam logic [1:0] MODE_SA0  = 2'b01;
    localparam logic [1:0] MODE_SA1  = 2'b10;
    localparam logic [1:0] MODE_FLIP = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACTIVE, S_DONE} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] dur_arm;
    logic             arm_ok;
    logic             busy_nx, active_nx, done_nx, inject;

    logic [SW-1:0]    cfg_stage;
    logic [1:0]       cfg_mode;
    logic [WIDTH-1:0] cfg_mask;
    logic [CNT_W-1:0] cfg_dur;

    logic [WIDTH-1:0] stage_r  [DEPTH];
    logic [WIDTH-1:0] stage_nx [DEPTH];

    logic [SW-1:0]    sel_r;
    logic             sel_chg;
    logic [WIDTH-1:0] prev, obs_cur;
    logic             obs_event;

    // Zero duration still yields one faulted edge
    assign dur_arm = (fi_duration == '0) ? CNT_W'(1) : fi_duration;

    // FSM state register and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            fi_busy   <= 1'b0;
            fi_active <= 1'b0;
            fi_done   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            fi_busy   <= busy_nx;
            fi_active <= active_nx;
            fi_done   <= done_nx;
        end
    end

    // FSM next state; cnt holds remaining WAIT or ACTIVE cycles
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        arm_ok   = 1'b0;
        case (state)
            S_IDLE: begin
                if (fi_arm) begin
                    arm_ok = 1'b1;
                    if (fi_delay != '0) begin
                        state_nx = S_WAIT;
                        cnt_nx   = fi_delay;
                    end else begin
                        state_nx = S_ACTIVE;
                        cnt_nx   = dur_arm;
                    end
                end
            end
            S_WAIT: begin
                if (fi_abort) begin
                    state_nx = S_IDLE;
                end else if (cnt == CNT_W'(1)) begin
                    state_nx = S_ACTIVE;
                    cnt_nx   = cfg_dur;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            S_ACTIVE: begin
                if (fi_abort) begin
                    state_nx = S_IDLE;
                end else if (cnt == CNT_W'(1)) begin
                    state_nx = S_DONE;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // FSM outputs: status follows the next state so the flops track the state register
    always_comb begin
        busy_nx   = 1'b0;
        active_nx = 1'b0;
        done_nx   = 1'b0;
        inject    = 1'b0;
        busy_nx   = (state_nx != S_IDLE);
        active_nx = (state_nx == S_ACTIVE);
        done_nx   = (state_nx == S_DONE);
        inject    = (state == S_ACTIVE) && !fi_abort;
    end

    // Fault configuration captured on an accepted arm
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_stage <= '0;
            cfg_mode  <= '0;
            cfg_mask  <= '0;
            cfg_dur   <= '0;
        end else if (arm_ok) begin
            cfg_stage <= fi_stage;
            cfg_mode  <= fi_mode;
            cfg_mask  <= fi_mask;
            cfg_dur   <= dur_arm;
        end
    end

    // Pipeline next values with the fault folded into the target stage
    always_comb begin
        stage_nx[0] = enable ? din : stage_r[0];
        for (int i = 1; i < int'(DEPTH); i++) begin
            stage_nx[i] = stage_r[i-1];
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (inject && (cfg_stage == SW'(i))) begin
                case (cfg_mode)
                    MODE_SA0:  stage_nx[i] = stage_nx[i] & ~cfg_mask;
                    MODE_SA1:  stage_nx[i] = stage_nx[i] | cfg_mask;
                    MODE_FLIP: stage_nx[i] = stage_nx[i] ^ cfg_mask;
                    default:   ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_r[i] <= '0;
            end
            dout_n <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_r[i] <= stage_nx[i];
            end
            dout_n <= ~stage_r[0];
        end
    end

    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_stage_q
        assign stage_q[g*WIDTH +: WIDTH] = stage_r[g];
    end
    assign dout = stage_r[DEPTH-1];

    // Observed stage value; an out-of-range select reads as zero
    always_comb begin
        obs_cur = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (sel_r == SW'(i)) obs_cur = stage_r[i];
        end
    end

    // prev belongs to the old select for one cycle after a switch, hence the blind cycle
    assign obs_event = !sel_chg && (obs_cur != prev);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_r        <= '0;
            sel_chg      <= 1'b0;
            prev         <= '0;
            obs_valid    <= 1'b0;
            obs_data     <= '0;
            obs_overflow <= 1'b0;
            obs_count    <= '0;
        end else begin
            sel_r   <= obs_sel;
            sel_chg <= (obs_sel != sel_r);
            prev    <= obs_cur;
            if (obs_event) begin
                if (!obs_valid || obs_ready) begin
                    obs_data  <= obs_cur;
                    obs_valid <= 1'b1;
                end else begin
                    obs_overflow <= 1'b1;
                end
                if (obs_count != {CNT_W{1'b1}}) obs_count <= obs_count + CNT_W'(1);
            end else if (obs_valid && obs_ready) begin
                obs_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fi_pipe_injector.sv
// Bench for fi_pipe_injector: directed scenarios plus random traffic against a
// timeline-based reference model compared on every falling clock edge.
module tb_fi_pipe_injector;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 3;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned SW    = $clog2(DEPTH);
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [WIDTH-1:0]       din = '0;
    logic                   enable = 1'b0;
    logic [DEPTH*WIDTH-1:0] stage_q;
    logic [WIDTH-1:0]       dout, dout_n;
    logic                   fi_arm = 1'b0;
    logic [SW-1:0]          fi_stage = '0;
    logic [1:0]             fi_mode = '0;
    logic [WIDTH-1:0]       fi_mask = '0;
    logic [CNT_W-1:0]       fi_delay = '0;
    logic [CNT_W-1:0]       fi_duration = '0;
    logic                   fi_abort = 1'b0;
    logic                   fi_busy, fi_active, fi_done;
    logic [SW-1:0]          obs_sel = '0;
    logic                   obs_valid;
    logic [WIDTH-1:0]       obs_data;
    logic                   obs_ready = 1'b0;
    logic                   obs_overflow;
    logic [CNT_W-1:0]       obs_count;

    fi_pipe_injector #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .din(din), .enable(enable),
        .stage_q(stage_q), .dout(dout), .dout_n(dout_n),
        .fi_arm(fi_arm), .fi_stage(fi_stage), .fi_mode(fi_mode), .fi_mask(fi_mask),
        .fi_delay(fi_delay), .fi_duration(fi_duration), .fi_abort(fi_abort),
        .fi_busy(fi_busy), .fi_active(fi_active), .fi_done(fi_done),
        .obs_sel(obs_sel), .obs_valid(obs_valid), .obs_data(obs_data),
        .obs_ready(obs_ready), .obs_overflow(obs_overflow), .obs_count(obs_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the fault is a window of edges counted from the arm edge
    logic [WIDTH-1:0] m_stage [DEPTH];
    logic [WIDTH-1:0] m_snap  [DEPTH];
    logic [WIDTH-1:0] m_dout_n, m_data, m_mask;
    logic [1:0]       m_mode;
    logic [SW-1:0]    m_sel, m_sel_prev;
    bit               m_armed, m_valid, m_ovf;
    int               m_edge, m_a, m_d, m_l, m_s, m_count;

    task automatic model_clear();
        for (int i = 0; i < int'(DEPTH); i++) begin
            m_stage[i] = '0;
            m_snap[i]  = '0;
        end
        m_dout_n = '0; m_data = '0; m_mask = '0; m_mode = '0;
        m_sel = '0; m_sel_prev = '0;
        m_armed = 1'b0; m_valid = 1'b0; m_ovf = 1'b0;
        m_edge = 0; m_a = 0; m_d = 0; m_l = 1; m_s = 0; m_count = 0;
    endtask

    task automatic model_edge();
        int k, idx;
        bit was, in_wait, in_act, in_done, ev;
        logic [WIDTH-1:0] nv [DEPTH];
        logic [WIDTH-1:0] cur, old;
        m_edge++;
        was     = m_armed;
        k       = m_edge - m_a;
        in_wait = was && (k >= 1) && (k <= m_d);
        in_act  = was && (k > m_d) && (k <= m_d + m_l);
        in_done = was && (k == m_d + m_l + 1);
        if ((in_wait || in_act) && fi_abort) m_armed = 1'b0;
        else if (in_done) m_armed = 1'b0;
        if (!was && fi_arm) begin
            m_armed = 1'b1;
            m_a     = m_edge;
            m_d     = int'(fi_delay);
            m_l     = (fi_duration == '0) ? 1 : int'(fi_duration);
            m_s     = int'(fi_stage);
            m_mode  = fi_mode;
            m_mask  = fi_mask;
        end
        idx = int'(m_sel);
        cur = '0;
        old = '0;
        if (idx < int'(DEPTH)) begin
            cur = m_stage[idx];
            old = m_snap[idx];
        end
        ev = (m_sel == m_sel_prev) && (cur != old);
        if (ev) begin
            if (!m_valid || obs_ready) begin
                m_valid = 1'b1;
                m_data  = cur;
            end else begin
                m_ovf = 1'b1;
            end
            if (m_count < CMAX) m_count++;
        end else if (m_valid && obs_ready) begin
            m_valid = 1'b0;
        end
        nv[0] = enable ? din : m_stage[0];
        for (int i = 1; i < int'(DEPTH); i++) nv[i] = m_stage[i-1];
        if (in_act && !fi_abort && (m_s < int'(DEPTH))) begin
            if (m_mode == 2'b01) nv[m_s] = nv[m_s] & ~m_mask;
            if (m_mode == 2'b10) nv[m_s] = nv[m_s] | m_mask;
            if (m_mode == 2'b11) nv[m_s] = nv[m_s] ^ m_mask;
        end
        m_dout_n = ~m_stage[0];
        for (int i = 0; i < int'(DEPTH); i++) begin
            m_snap[i]  = m_stage[i];
            m_stage[i] = nv[i];
        end
        m_sel_prev = m_sel;
        m_sel      = obs_sel;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_clear();
            else model_edge();
        end
    end

    // Compare every output against the model on each falling edge
    initial begin : compare
        logic [DEPTH*WIDTH-1:0] eq;
        int nk;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int i = 0; i < int'(DEPTH); i++) eq[i*WIDTH +: WIDTH] = m_stage[i];
                nk = m_edge + 1 - m_a;
                check("stage_q", 32'(stage_q), 32'(eq));
                check("dout", 32'(dout), 32'(m_stage[DEPTH-1]));
                check("dout_n", 32'(dout_n), 32'(m_dout_n));
                check("fi_busy", 32'(fi_busy), 32'(m_armed));
                check("fi_active", 32'(fi_active),
                      32'(m_armed && (nk > m_d) && (nk <= m_d + m_l)));
                check("fi_done", 32'(fi_done), 32'(m_armed && (nk == m_d + m_l + 1)));
                check("obs_valid", 32'(obs_valid), 32'(m_valid));
                check("obs_data", 32'(obs_data), 32'(m_data));
                check("obs_overflow", 32'(obs_overflow), 32'(m_ovf));
                check("obs_count", 32'(obs_count), 32'(m_count));
            end
        end
    end

    task automatic nx();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        nx();
        reset = 1'b0;
        nx();
    endtask

    task automatic arm(input int s, input logic [1:0] mode, input logic [WIDTH-1:0] m,
                       input int d, input int l);
        fi_arm      = 1'b1;
        fi_stage    = SW'(s);
        fi_mode     = mode;
        fi_mask     = m;
        fi_delay    = CNT_W'(d);
        fi_duration = CNT_W'(l);
    endtask

    initial begin
        nx();
        chk_en = 1'b1;
        nx();
        check("rst_stage_q", 32'(stage_q), 32'h0);
        check("rst_busy", 32'(fi_busy), 32'h0);
        check("rst_obs_count", 32'(obs_count), 32'h0);
        reset = 1'b0;

        // Basic pipeline flow
        din = 8'hA5; enable = 1'b1; nx();
        check("t1_stage0", 32'(stage_q[7:0]), 32'hA5);
        din = 8'h00; nx();
        check("t1_dout_n", 32'(dout_n), 32'h5A);
        check("t1_dout_e2", 32'(dout), 32'h00);
        nx();
        check("t1_dout_e3", 32'(dout), 32'hA5);
        nx();
        check("t1_dout_e4", 32'(dout), 32'h00);

        // Delayed SA1 on stage 1
        nx(); nx(); nx();
        arm(1, 2'b10, 8'h0F, 2, 3); nx();
        fi_arm = 1'b0;
        check("t2_busy_arm", 32'(fi_busy), 32'h1);
        for (int j = 1; j <= 7; j++) begin
            nx();
            check("t2_stage1", 32'(stage_q[15:8]), (j >= 3 && j <= 5) ? 32'h0F : 32'h00);
            check("t2_dout", 32'(dout), (j >= 4 && j <= 6) ? 32'h0F : 32'h00);
            check("t2_done", 32'(fi_done), 32'(j == 5));
            check("t2_busy", 32'(fi_busy), 32'(j <= 5));
        end

        // Hold, then flip on held stage 0 with a second arm while busy
        din = 8'h3C; enable = 1'b1; nx();
        enable = 1'b0; din = 8'h55; nx(); nx();
        check("t3_hold", 32'(stage_q[7:0]), 32'h3C);
        arm(0, 2'b11, 8'hFF, 0, 2); nx();
        fi_mode = 2'b10; nx();
        check("t3_flip1", 32'(stage_q[7:0]), 32'hC3);
        nx();
        check("t3_flip2", 32'(stage_q[7:0]), 32'h3C);
        check("t3_done", 32'(fi_done), 32'h1);
        fi_arm = 1'b0; nx();
        check("t3_ignored", 32'(stage_q[7:0]), 32'h3C);
        check("t3_idle", 32'(fi_busy), 32'h0);

        // SA0 with abort after two active cycles
        din = 8'hFF; enable = 1'b1; nx(); nx(); nx();
        arm(1, 2'b01, 8'hFF, 0, 10); nx();
        fi_arm = 1'b0; nx();
        check("t4_c1", 32'(stage_q[15:8]), 32'h00);
        nx();
        check("t4_c2", 32'(stage_q[15:8]), 32'h00);
        fi_abort = 1'b1; nx();
        check("t4_abort_stage1", 32'(stage_q[15:8]), 32'hFF);
        check("t4_abort_busy", 32'(fi_busy), 32'h0);
        check("t4_abort_done", 32'(fi_done), 32'h0);
        fi_abort = 1'b0; nx();
        check("t4_done_after", 32'(fi_done), 32'h0);
        check("t4_dout", 32'(dout), 32'hFF);

        // Reset in the middle of ACTIVE
        arm(1, 2'b01, 8'hFF, 0, 10); nx();
        fi_arm = 1'b0; nx();
        reset = 1'b1; #1;
        check("t4_rst_stage_q", 32'(stage_q), 32'h0);
        check("t4_rst_dout_n", 32'(dout_n), 32'h0);
        check("t4_rst_active", 32'(fi_active), 32'h0);
        nx();
        reset = 1'b0;

        // Observation backpressure and overflow
        obs_sel = '0; obs_ready = 1'b0; din = 8'h00; enable = 1'b1; nx();
        din = 8'h11; nx();
        din = 8'h22; nx();
        enable = 1'b0; nx(); nx();
        check("t5_valid", 32'(obs_valid), 32'h1);
        check("t5_data", 32'(obs_data), 32'h11);
        check("t5_ovf", 32'(obs_overflow), 32'h1);
        check("t5_count", 32'(obs_count), 32'h2);
        obs_ready = 1'b1; nx();
        obs_ready = 1'b0;
        check("t5_cleared", 32'(obs_valid), 32'h0);

        // Select switch onto a differing but stable stage
        nx(); nx(); nx();
        arm(2, 2'b10, 8'h0F, 0, 15); nx();
        fi_arm = 1'b0; nx(); nx();
        obs_sel = SW'(2); nx(); nx(); nx(); nx();
        check("t6_stage2", 32'(dout), 32'h2F);
        check("t6_count", 32'(obs_count), 32'h2);
        check("t6_valid", 32'(obs_valid), 32'h0);
        obs_sel = '0; fi_abort = 1'b1; nx();
        fi_abort = 1'b0;

        // Count saturation
        obs_ready = 1'b1; enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            din = (i % 2 == 0) ? 8'h5A : 8'hA5;
            nx();
        end
        check("t6_saturate", 32'(obs_count), 32'(CMAX));

        // Random traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            din       = WIDTH'($urandom);
            enable    = ($urandom_range(0, 1) == 1);
            obs_ready = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 9) == 0) obs_sel = SW'($urandom_range(0, 3));
            fi_arm    = ($urandom_range(0, 7) == 0);
            fi_stage  = SW'($urandom_range(0, 3));
            fi_mode   = 2'($urandom);
            fi_mask   = WIDTH'($urandom);
            fi_delay  = CNT_W'($urandom_range(0, 6));
            fi_duration = CNT_W'($urandom_range(0, 6));
            fi_abort  = ($urandom_range(0, 29) == 0);
            reset     = ($urandom_range(0, 299) == 0);
            nx();
            reset = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
